// File: rtl/pr_decouple_seq_pkg.sv
// Shared types for the per-region decouple/PR-reset sequencer.
// The state encoding is exported so the status register path can decode m_state.
package pr_decouple_seq_pkg;

  localparam int PR_STATE_W = 3;

  typedef enum logic [PR_STATE_W-1:0] {
    ST_ACTIVE    = 3'd0,
    ST_DRAIN     = 3'd1,
    ST_DECOUPLED = 3'd2,
    ST_PR_RST    = 3'd3,
    ST_SETTLE    = 3'd4
  } pr_seq_state_t;

  localparam logic [PR_STATE_W-1:0] PR_ENC_ACTIVE    = 3'd0;
  localparam logic [PR_STATE_W-1:0] PR_ENC_DRAIN     = 3'd1;
  localparam logic [PR_STATE_W-1:0] PR_ENC_DECOUPLED = 3'd2;
  localparam logic [PR_STATE_W-1:0] PR_ENC_PR_RST    = 3'd3;
  localparam logic [PR_STATE_W-1:0] PR_ENC_SETTLE    = 3'd4;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pr_decouple_seq_if.sv
// Request/status bundle between the control-register block, the sequencer and the regions.
// The slave modport is the sequencer's view; master is the driving side.
interface pr_decouple_seq_if #(
  parameter int N_REGIONS = 1
);
  import pr_decouple_seq_pkg::*;

  logic [N_REGIONS-1:0]            s_decouple_req;
  logic [N_REGIONS-1:0]            s_rst_pr_req;
  logic [N_REGIONS-1:0]            s_busy;
  logic [N_REGIONS-1:0]            m_quiesce;
  logic [N_REGIONS-1:0]            m_decouple;
  logic [N_REGIONS-1:0]            m_rst_pr;
  logic [N_REGIONS-1:0]            m_timeout;
  logic [PR_STATE_W*N_REGIONS-1:0] m_state;

  modport master (
    output s_decouple_req, s_rst_pr_req, s_busy,
    input  m_quiesce, m_decouple, m_rst_pr, m_timeout, m_state
  );

  modport slave (
    input  s_decouple_req, s_rst_pr_req, s_busy,
    output m_quiesce, m_decouple, m_rst_pr, m_timeout, m_state
  );

endinterface

// File: rtl/pr_decouple_seq_region_seq.sv
// One region's sequencer: quiesce, bounded drain, decouple, minimum-length PR reset, settle.
// A single counter is shared by the drain, reset and settle phases since they never overlap.
module pr_region_seq
  import pr_decouple_seq_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  i_decouple_req,
  input  logic                  i_rst_pr_req,
  input  logic                  i_busy,
  output logic                  o_quiesce,
  output logic                  o_decouple,
  output logic                  o_rst_pr,
  output logic                  o_timeout,
  output logic [PR_STATE_W-1:0] o_state
);

  localparam int CNT_W = $clog2(maxOf3(DRAIN_TIMEOUT, RST_CYCLES, SETTLE_CYCLES)) + 1;
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  pr_seq_state_t    r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_timeout;

  pr_seq_state_t    w_nextState;
  logic [CNT_W-1:0] w_nextCount;
  logic             w_nextTimeout;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state   <= ST_ACTIVE;
      r_count   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_count   <= w_nextCount;
      r_timeout <= w_nextTimeout;
    end
  end

  // Abort beats drain completion; the PR reset counter saturates so a held request only extends it.
  always_comb begin
    w_nextState   = r_state;
    w_nextCount   = r_count;
    w_nextTimeout = r_timeout;
    case (r_state)
      ST_ACTIVE: begin
        if (i_decouple_req) begin
          w_nextState   = ST_DRAIN;
          w_nextCount   = '0;
          w_nextTimeout = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (!i_decouple_req) begin
          w_nextState = ST_ACTIVE;
        end else if (!i_busy) begin
          w_nextState = ST_DECOUPLED;
        end else if (r_count == DRAIN_LAST) begin
          w_nextState   = ST_DECOUPLED;
          w_nextTimeout = 1'b1;
        end else begin
          w_nextCount = r_count + CNT_W'(1);
        end
      end
      ST_DECOUPLED: begin
        if (i_rst_pr_req) begin
          w_nextState = ST_PR_RST;
          w_nextCount = '0;
        end else if (!i_decouple_req) begin
          w_nextState = ST_SETTLE;
          w_nextCount = '0;
        end
      end
      ST_PR_RST: begin
        if (r_count == RST_LAST) begin
          if (!i_rst_pr_req) begin
            w_nextState = ST_DECOUPLED;
          end
        end else begin
          w_nextCount = r_count + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (r_count == SETTLE_LAST) begin
          w_nextState = ST_ACTIVE;
        end else begin
          w_nextCount = r_count + CNT_W'(1);
        end
      end
      default: begin
        w_nextState = ST_ACTIVE;
        w_nextCount = '0;
      end
    endcase
  end

  assign o_quiesce  = (r_state != ST_ACTIVE);
  assign o_decouple = (r_state == ST_DECOUPLED) || (r_state == ST_PR_RST);
  assign o_rst_pr   = (r_state == ST_PR_RST);
  assign o_timeout  = r_timeout;
  assign o_state    = r_state;

endmodule

// File: rtl/pr_decouple_seq.sv
// Top level: one independent pr_region_seq per dynamic region, no cross-region arbitration.
module pr_decouple_seq
  import pr_decouple_seq_pkg::*;
#(
  parameter int N_REGIONS     = 1,
  parameter int DRAIN_TIMEOUT = 4096,
  parameter int RST_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input logic              aclk,
  input logic              aresetn,
  pr_decouple_seq_if.slave bus
);

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
    pr_region_seq #(
      .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
      .RST_CYCLES    (RST_CYCLES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_seq (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .i_decouple_req (bus.s_decouple_req[g]),
      .i_rst_pr_req   (bus.s_rst_pr_req[g]),
      .i_busy         (bus.s_busy[g]),
      .o_quiesce      (bus.m_quiesce[g]),
      .o_decouple     (bus.m_decouple[g]),
      .o_rst_pr       (bus.m_rst_pr[g]),
      .o_timeout      (bus.m_timeout[g]),
      .o_state        (bus.m_state[PR_STATE_W*g +: PR_STATE_W])
    );
  end

endmodule

// File: tb/tb_pr_decouple_seq.sv
// Scoreboard bench for pr_decouple_seq: directed requests push hand-computed per-cycle
// expectations; a negedge monitor pops and compares them independently of the stimulus.
module tb_pr_decouple_seq;
  import pr_decouple_seq_pkg::*;

  localparam int NR = 2;
  localparam int DT = 32;
  localparam int RC = 16;
  localparam int SC = 8;

  typedef struct {
    int         cyc;
    int         rgn;
    logic [6:0] val;
    string      tag;
  } expect_t;

  logic    aclk = 1'b0;
  logic    aresetn = 1'b0;
  int      cyc = 0;
  int      checksTotal = 0;
  int      checksPassed = 0;
  expect_t expQ[$];

  pr_decouple_seq_if #(.N_REGIONS(NR)) bus ();

  pr_decouple_seq #(
    .N_REGIONS     (NR),
    .DRAIN_TIMEOUT (DT),
    .RST_CYCLES    (RC),
    .SETTLE_CYCLES (SC)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus.slave)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  // Packed as {state, timeout, rst_pr, decouple, quiesce}.
  task automatic expectAt(input int c, input int r, input logic [2:0] st, input logic to,
                          input logic rst, input logic dec, input logic q, input string tag);
    expect_t e;
    e.cyc = c;
    e.rgn = r;
    e.val = {st, to, rst, dec, q};
    e.tag = tag;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input expect_t e);
    logic [6:0] act;
    act = {bus.m_state[3*e.rgn +: 3], bus.m_timeout[e.rgn], bus.m_rst_pr[e.rgn],
           bus.m_decouple[e.rgn], bus.m_quiesce[e.rgn]};
    checksTotal++;
    if (act === e.val) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s (cycle %0d region %0d): got {st,to,rst,dec,q}=%b, want %b",
               e.tag, e.cyc, e.rgn, act, e.val);
    end
  endtask

  always @(negedge aclk) begin
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].cyc == cyc) begin
        checkOutput(expQ[i]);
        expQ.delete(i);
      end else if (expQ[i].cyc < cyc) begin
        checksTotal++;
        $display("[TB] FAIL %s missed: cycle %0d, now %0d", expQ[i].tag, expQ[i].cyc, cyc);
        expQ.delete(i);
      end
    end
  end

  task automatic gotoCycle(input int c);
    while (cyc < c) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int c, input int r, input logic dec, input logic rst,
                               input logic busy);
    gotoCycle(c);
    bus.s_decouple_req[r] = dec;
    bus.s_rst_pr_req[r]   = rst;
    bus.s_busy[r]         = busy;
  endtask

  initial begin
    bus.s_decouple_req = '0;
    bus.s_rst_pr_req   = '0;
    bus.s_busy         = '0;
    expectAt(3, 0, 3'd0, 0, 0, 0, 0, "reset_r0");
    expectAt(3, 1, 3'd0, 0, 0, 0, 0, "reset_r1");
    gotoCycle(3);
    aresetn = 1'b1;
    expectAt(5, 0, 3'd0, 0, 0, 0, 0, "idle_after_reset");

    // Idle region decouple, then re-couple through SETTLE
    applyStimulus(10, 0, 1, 0, 0);
    expectAt(10, 0, 3'd0, 0, 0, 0, 0, "s1_pre");
    expectAt(11, 0, 3'd1, 0, 0, 0, 1, "s1_quiesce");
    expectAt(12, 0, 3'd2, 0, 0, 1, 1, "s1_decouple");
    expectAt(12, 1, 3'd0, 0, 0, 0, 0, "s1_r1_idle");
    applyStimulus(20, 0, 0, 0, 0);
    expectAt(21, 0, 3'd4, 0, 0, 0, 1, "recouple_dec_low");
    expectAt(28, 0, 3'd4, 0, 0, 0, 1, "settle_hold");
    expectAt(29, 0, 3'd0, 0, 0, 0, 0, "settle_done");

    // Drain waits for busy to drop
    applyStimulus(35, 0, 0, 0, 1);
    applyStimulus(40, 0, 1, 0, 1);
    expectAt(41, 0, 3'd1, 0, 0, 0, 1, "drain_enter");
    expectAt(60, 0, 3'd1, 0, 0, 0, 1, "drain_wait");
    applyStimulus(60, 0, 1, 0, 0);
    expectAt(61, 0, 3'd2, 0, 0, 1, 1, "drain_done");
    applyStimulus(65, 0, 0, 0, 0);
    expectAt(73, 0, 3'd4, 0, 0, 0, 1, "s2_settle");
    expectAt(74, 0, 3'd0, 0, 0, 0, 0, "s2_active");

    // Drain timeout, sticky flag, clear on next drain, then abort
    applyStimulus(100, 0, 1, 0, 1);
    expectAt(101, 0, 3'd1, 0, 0, 0, 1, "to_drain_first");
    expectAt(132, 0, 3'd1, 0, 0, 0, 1, "to_drain_last");
    expectAt(133, 0, 3'd2, 1, 0, 1, 1, "to_decouple");
    applyStimulus(140, 0, 0, 0, 1);
    expectAt(141, 0, 3'd4, 1, 0, 0, 1, "to_settle_sticky");
    expectAt(149, 0, 3'd0, 1, 0, 0, 0, "to_active_sticky");
    applyStimulus(150, 0, 1, 0, 1);
    expectAt(151, 0, 3'd1, 0, 0, 0, 1, "to_cleared");
    applyStimulus(153, 0, 0, 0, 1);
    expectAt(153, 0, 3'd1, 0, 0, 0, 1, "abort_pre");
    expectAt(154, 0, 3'd0, 0, 0, 0, 0, "abort_active");
    applyStimulus(155, 0, 0, 0, 0);

    // One-cycle PR reset pulse gives the minimum length; region 1 ignores rst in ACTIVE
    applyStimulus(160, 0, 1, 0, 0);
    expectAt(162, 0, 3'd2, 0, 0, 1, 1, "s4_decoupled");
    applyStimulus(165, 0, 1, 1, 0);
    applyStimulus(165, 1, 0, 1, 0);
    expectAt(165, 0, 3'd2, 0, 0, 1, 1, "pulse_pre");
    expectAt(166, 0, 3'd3, 0, 1, 1, 1, "pulse_rst_first");
    expectAt(170, 1, 3'd0, 0, 0, 0, 0, "r1_ignores_rst");
    expectAt(181, 0, 3'd3, 0, 1, 1, 1, "pulse_rst_last");
    expectAt(182, 0, 3'd2, 0, 0, 1, 1, "pulse_exit");
    applyStimulus(166, 0, 1, 0, 0);
    applyStimulus(175, 1, 0, 0, 0);

    // Held PR reset extends; dropping decouple during PR_RST waits; SETTLE is not aborted
    applyStimulus(190, 0, 1, 1, 0);
    expectAt(191, 0, 3'd3, 0, 1, 1, 1, "held_first");
    expectAt(210, 0, 3'd3, 0, 1, 1, 1, "held_dec_drop_ignored");
    expectAt(230, 0, 3'd3, 0, 1, 1, 1, "held_last");
    expectAt(231, 0, 3'd2, 0, 0, 1, 1, "held_exit");
    expectAt(232, 0, 3'd4, 0, 0, 0, 1, "held_settle");
    applyStimulus(200, 0, 0, 1, 0);
    applyStimulus(230, 0, 0, 0, 0);
    applyStimulus(235, 0, 1, 0, 0);
    expectAt(239, 0, 3'd4, 0, 0, 0, 1, "settle_req_kept");
    expectAt(240, 0, 3'd0, 0, 0, 0, 0, "settle_not_aborted");
    expectAt(241, 0, 3'd1, 0, 0, 0, 1, "redrain");
    expectAt(242, 0, 3'd2, 0, 0, 1, 1, "redecouple");

    // Reset in the middle of PR_RST, region 1 draining
    applyStimulus(245, 0, 1, 1, 0);
    expectAt(246, 0, 3'd3, 0, 1, 1, 1, "s7_rst");
    expectAt(248, 1, 3'd0, 0, 0, 0, 0, "s7_r1_active");
    expectAt(250, 0, 3'd3, 0, 1, 1, 1, "s7_rst_hold");
    applyStimulus(249, 1, 1, 0, 1);
    expectAt(251, 1, 3'd1, 0, 0, 0, 1, "s7_r1_drain");
    gotoCycle(252);
    aresetn = 1'b0;
    expectAt(253, 0, 3'd0, 0, 0, 0, 0, "midrst_r0");
    expectAt(253, 1, 3'd0, 0, 0, 0, 0, "midrst_r1");
    applyStimulus(254, 0, 0, 0, 0);
    applyStimulus(254, 1, 0, 0, 0);
    gotoCycle(255);
    aresetn = 1'b1;
    expectAt(258, 0, 3'd0, 0, 0, 0, 0, "post_rst_r0");
    expectAt(258, 1, 3'd0, 0, 0, 0, 0, "post_rst_r1");

    gotoCycle(262);
    if (expQ.size() != 0) begin
      checksTotal++;
      $display("[TB] FAIL leftover_expectations: got %0d pending, want 0", expQ.size());
    end
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  initial begin
    #100000;
    checksTotal++;
    $display("[TB] FAIL watchdog: got cycle %0d, want completion by cycle 262", cyc);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
